// File: rtl/egr_rrs_pkg.sv
// rtl/egr_rrs_pkg.sv - shared defaults and types for the egress response reorder buffer
package egr_rrs_pkg;

  localparam int RRS_NUM_TAGS = 16;
  localparam int RRS_DATA_W   = 64;
  localparam int RRS_TAG_W    = $clog2(RRS_NUM_TAGS);

  typedef logic [RRS_TAG_W-1:0]  rrs_tag_t;
  typedef logic [RRS_DATA_W-1:0] rrs_data_t;
  // Tag index plus one wrap bit so full and empty stay distinguishable.
  typedef logic [RRS_TAG_W:0]    rrs_ptr_t;

  function automatic rrs_tag_t rrs_ptr_idx(input rrs_ptr_t p);
    return p[RRS_TAG_W-1:0];
  endfunction

endpackage

// File: rtl/egr_rrs_rob_if.sv
// rtl/egr_rrs_rob_if.sv - tag allocation, mesh response and in-order output bundle
interface egr_rrs_rob_if
  import egr_rrs_pkg::*;
#(
  parameter int NUM_TAGS = RRS_NUM_TAGS,
  parameter int DATA_W   = RRS_DATA_W
);
  localparam int TAG_W = $clog2(NUM_TAGS);

  logic              alloc_req;
  logic              alloc_gnt;
  logic [TAG_W-1:0]  alloc_tag;
  logic              rsp_valid;
  logic [TAG_W-1:0]  rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W:0]    occupancy;
  logic              rsp_err;

  modport master (
    output alloc_req, rsp_valid, rsp_tag, rsp_data, out_ready,
    input  alloc_gnt, alloc_tag, out_valid, out_tag, out_data, occupancy, rsp_err
  );

  modport slave (
    input  alloc_req, rsp_valid, rsp_tag, rsp_data, out_ready,
    output alloc_gnt, alloc_tag, out_valid, out_tag, out_data, occupancy, rsp_err
  );

endinterface

// File: rtl/egr_rrs_rob_mem.sv
// rtl/egr_rrs_rob_mem.sv - response payload store, one write port and one async read port
module egr_rrs_rob_mem
  import egr_rrs_pkg::*;
#(
  parameter int DEPTH = RRS_NUM_TAGS,
  parameter int WIDTH = RRS_DATA_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/egr_rrs_rob.sv
// rtl/egr_rrs_rob.sv - reorder buffer returning mesh read responses in tag allocation order
module egr_rrs_rob
  import egr_rrs_pkg::*;
#(
  parameter int NUM_TAGS = RRS_NUM_TAGS,
  parameter int DATA_W   = RRS_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  egr_rrs_rob_if.slave bus
);

  localparam int TAG_W = $clog2(NUM_TAGS);
  localparam int PTR_W = TAG_W + 1;

  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [PTR_W-1:0]    occ;
  logic [TAG_W-1:0]    head_idx;
  logic [TAG_W-1:0]    tail_idx;
  logic [TAG_W-1:0]    rsp_off;
  logic [NUM_TAGS-1:0] rcvd_q;
  logic [NUM_TAGS-1:0] rcvd_d;
  logic                full;
  logic                gnt;
  logic                in_window;
  logic                rsp_legal;
  logic                pop;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rd_data;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign occ      = tail_q - head_q;
  assign full     = (occ == PTR_W'(NUM_TAGS));

  // Full is judged on pre-edge state only; a same-cycle pop never frees a slot.
  assign gnt = bus.alloc_req & ~full & ~rst;

  // Distance from head modulo NUM_TAGS; inside the window iff below occupancy.
  assign rsp_off   = bus.rsp_tag - head_idx;
  assign in_window = ({1'b0, rsp_off} < occ);
  assign rsp_legal = bus.rsp_valid & in_window & ~rcvd_q[bus.rsp_tag] & ~rst;

  assign pop = rcvd_q[head_idx] & bus.out_ready & ~rst;

  // A legal response never targets the popping head slot, since that rcvd bit is set.
  always_comb begin
    rcvd_d = rcvd_q;
    if (rsp_legal) begin
      rcvd_d[bus.rsp_tag] = 1'b1;
    end
    if (pop) begin
      rcvd_d[head_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      rcvd_q    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (gnt) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      rcvd_q    <= rcvd_d;
      rsp_err_q <= bus.rsp_valid & ~rsp_legal;
    end
  end

  egr_rrs_rob_mem #(
    .DEPTH (NUM_TAGS),
    .WIDTH (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (rsp_legal),
    .waddr (bus.rsp_tag),
    .wdata (bus.rsp_data),
    .raddr (head_idx),
    .rdata (rd_data)
  );

  assign bus.alloc_gnt = gnt;
  assign bus.alloc_tag = tail_idx;
  assign bus.out_valid = rcvd_q[head_idx] & ~rst;
  assign bus.out_tag   = head_idx;
  assign bus.out_data  = rd_data;
  assign bus.occupancy = rst ? '0 : occ;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_egr_rrs_rob.sv
// tb/tb_egr_rrs_rob.sv - randomized and directed bench for egr_rrs_rob against a queue model
module tb_egr_rrs_rob;
  import egr_rrs_pkg::*;

  localparam int NT    = 16;
  localparam int DW    = 64;
  localparam int TAG_W = $clog2(NT);

  logic clk;
  logic rst;

  egr_rrs_rob_if #(.NUM_TAGS(NT), .DATA_W(DW)) bus ();

  egr_rrs_rob #(.NUM_TAGS(NT), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: outstanding tags in allocation order, plus per-tag received data.
  int unsigned q[$];
  bit          have[NT];
  rrs_data_t   mdat[NT];
  int          acnt;
  bit          merr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    foreach (have[i]) have[i] = 1'b0;
    acnt = 0;
    merr = 1'b0;
  endtask

  task automatic cyc(input bit r, input bit ar, input bit rv, input int rt,
                     input rrs_data_t rd, input bit ordy);
    bit exp_gnt;
    bit exp_ov;
    bit hit;
    bit legal;
    int exp_occ;
    @(negedge clk);
    rst           = r;
    bus.alloc_req = ar;
    bus.rsp_valid = rv;
    bus.rsp_tag   = TAG_W'(rt);
    bus.rsp_data  = rd;
    bus.out_ready = ordy;
    #1;
    exp_occ = r ? 0 : q.size();
    exp_gnt = !r && ar && (q.size() < NT);
    exp_ov  = !r && (q.size() > 0) && have[q[0]];
    check("alloc_gnt", 64'(bus.alloc_gnt), 64'(exp_gnt));
    if (exp_gnt) check("alloc_tag", 64'(bus.alloc_tag), 64'(acnt % NT));
    check("occupancy", 64'(bus.occupancy), 64'(exp_occ));
    check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      check("out_tag", 64'(bus.out_tag), 64'(q[0]));
      check("out_data", bus.out_data, mdat[q[0]]);
    end
    check("rsp_err", 64'(bus.rsp_err), 64'(merr));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      hit = 1'b0;
      foreach (q[i]) if (q[i] == rt) hit = 1'b1;
      legal = rv && hit && !have[rt];
      merr  = rv && !legal;
      if (legal) begin
        have[rt] = 1'b1;
        mdat[rt] = rd;
      end
      if (exp_ov && ordy) begin
        have[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (exp_gnt) begin
        q.push_back(acnt % NT);
        acnt++;
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) cyc(0, 0, 0, 0, '0, ordy);
  endtask

  task automatic do_reset(input int n);
    repeat (n) cyc(1, 0, 0, 0, '0, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.alloc_req = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_tag   = '0;
    bus.rsp_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();

    do_reset(2);
    idle(1, 1);

    // In-order traffic
    repeat (3) cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 0, 1, 0, 64'hA, 1);
    cyc(0, 0, 1, 1, 64'hB, 1);
    cyc(0, 0, 1, 2, 64'hC, 1);
    idle(3, 1);
    check("inorder_occ", 64'(bus.occupancy), 64'd0);

    // Reorder
    do_reset(1);
    repeat (4) cyc(0, 1, 0, 0, '0, 1);
    for (int t = 3; t >= 0; t--) cyc(0, 0, 1, t, 64'h100 + 64'(t), 1);
    idle(5, 1);

    // Full, no bypass on same-cycle pop, then wrapped grant of tag 0
    do_reset(1);
    repeat (17) cyc(0, 1, 0, 0, '0, 0);
    cyc(0, 0, 1, 0, 64'hF00D, 0);
    cyc(0, 1, 0, 0, '0, 1);
    cyc(0, 1, 0, 0, '0, 0);
    idle(2, 0);

    // Errors: unallocated tag and duplicate response
    do_reset(1);
    repeat (2) cyc(0, 1, 0, 0, '0, 0);
    cyc(0, 0, 1, 5, 64'h5555, 0);
    idle(1, 0);
    cyc(0, 0, 1, 1, 64'h1111, 0);
    cyc(0, 0, 1, 1, 64'h2222, 0);
    cyc(0, 0, 1, 0, 64'h0000_0000_0000_00AA, 0);
    idle(3, 1);

    // Backpressure
    do_reset(1);
    cyc(0, 1, 0, 0, '0, 0);
    cyc(0, 0, 1, 0, 64'hDEAD_BEEF, 0);
    idle(5, 0);
    idle(2, 1);

    // Reset mid-flight, then a late response
    do_reset(1);
    repeat (6) cyc(0, 1, 0, 0, '0, 0);
    for (int t = 0; t < 3; t++) cyc(0, 0, 1, t, 64'h700 + 64'(t), 0);
    do_reset(1);
    cyc(0, 0, 1, 2, 64'hBAD, 1);
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit        r;
      bit        ar;
      bit        rv;
      bit        ordy;
      int        rt;
      rrs_data_t rd;
      r    = ($urandom_range(0, 299) == 0);
      ar   = ($urandom_range(0, 2) != 0);
      rv   = ($urandom_range(0, 1) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      if (q.size() > 0 && $urandom_range(0, 4) != 0)
        rt = int'(q[$urandom_range(0, q.size() - 1)]);
      else
        rt = int'($urandom_range(0, NT - 1));
      rd = {$urandom, $urandom};
      cyc(r, ar, rv, rt, rd, ordy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/egr_rrs_rob.md
EGR_RRS_ROB -- requirements
Module: egr_rrs_rob

Interface
REQ-001 Parameter NUM_TAGS, default 16: reorder depth, power of two, at least 2.
REQ-002 Parameter DATA_W, default 64: response data width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state is updated on the rising edge of clk.
REQ-004 clk  input  1  block clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 alloc_req  input  1  requestor asks for a tag before it issues a mesh read.
REQ-007 alloc_gnt  output  1  tag granted this cycle (combinational).
REQ-008 alloc_tag  output  log2(NUM_TAGS)  tag granted; valid only when alloc_gnt=1.
REQ-009 rsp_valid  input  1  mesh read response present; no backpressure toward the mesh.
REQ-010 rsp_tag  input  log2(NUM_TAGS)  tag of the response.
REQ-011 rsp_data  input  DATA_W  response payload.
REQ-012 out_valid  output  1  in-order response available to the consumer.
REQ-013 out_ready  input  1  consumer accepts the response.
REQ-014 out_tag  output  log2(NUM_TAGS)  tag of the presented response.
REQ-015 out_data  output  DATA_W  payload of the presented response.
REQ-016 occupancy  output  log2(NUM_TAGS)+1  number of allocated tags not yet popped.
REQ-017 rsp_err  output  1  one-cycle pulse: the previous cycle's response was illegal.

Function
REQ-018 Pointers head and tail: log2(NUM_TAGS)+1 bits each, including a wrap bit, both free-running modulo 2*NUM_TAGS; occupancy = tail - head.
REQ-019 full = (occupancy == NUM_TAGS); empty = (occupancy == 0).
REQ-020 alloc_gnt = alloc_req AND NOT full; alloc_tag = tail index bits; tail increments on grant.
REQ-021 A pop in the same cycle does not free a slot for an allocation in that cycle: full is evaluated on pre-edge state, with no bypass.
REQ-022 A response is legal when rsp_tag is in the outstanding window [head, tail) modulo NUM_TAGS and rcvd[rsp_tag] = 0.
REQ-023 On a legal response: store rsp_data in slot rsp_tag and set rcvd[rsp_tag] at the clock edge.
REQ-024 On an illegal response: drop the data, change no state, and pulse rsp_err for one cycle in the next cycle.
REQ-025 out_valid = rcvd[head index]; out_tag = head index; out_data = slot[head index]. Minimum latency from rsp_valid to out_valid is 1 cycle.
REQ-026 Pop on out_valid AND out_ready: clear rcvd[head index] and increment head. Throughput is 1 response per cycle.
REQ-027 out_valid=1 with out_ready=0 holds out_tag and out_data stable until the pop.
REQ-028 A response to the head tag in the cycle it pops is illegal, because rcvd is already set.
REQ-029 Allocation, a legal response and a pop to distinct slots in the same cycle all take effect together.
REQ-030 Occupancy changes by +1, -1 or 0 per cycle; simultaneous alloc and pop leave it unchanged.
REQ-031 Pointer wrap from 2*NUM_TAGS-1 to 0 is seamless; no bubble.

Reset
REQ-032 On rst: head=0, tail=0, rcvd all 0, rsp_err=0.
REQ-033 While rst=1: out_valid=0, alloc_gnt=0, occupancy=0.
REQ-034 The data array is not reset.
REQ-035 Reset mid-operation discards all outstanding tags and stored data.
REQ-036 Responses arriving during or after reset for tags from before reset are treated as illegal.

Structure
REQ-037 Package egr_rrs_pkg SHALL hold: NUM_TAGS default, DATA_W default, rrs_tag_t, rrs_data_t and rrs_ptr_t (tag plus wrap bit).
REQ-038 Storage is sub-module egr_rrs_rob_mem: 1 write port and 1 async read port, NUM_TAGS x DATA_W, no reset.
REQ-039 Pointers, rcvd bits, legality check and error flop stay in egr_rrs_rob.

Verification
REQ-040 In-order traffic: allocate tags 0,1,2; respond 0,1,2 with data A,B,C; out_ready=1 -> out returns (0,A),(1,B),(2,C) on consecutive cycles, occupancy ends at 0.
REQ-041 Reorder: allocate 0..3; respond 3,2,1,0 -> no out_valid until tag 0 arrives; then tags 0,1,2,3 emerge on 4 back-to-back cycles.
REQ-042 Full: allocate 16 with no responses -> the 17th alloc_req gets alloc_gnt=0 and occupancy=16. Respond and pop tag 0 -> the next cycle grants tag 0 with wrap bit set.
REQ-043 Errors: respond to an unallocated tag 5 with occupancy 2 -> rsp_err pulses one cycle later and state is unchanged. A duplicate response to tag 1 -> rsp_err pulses and the original data is preserved.
REQ-044 Backpressure: head received and out_ready=0 for 5 cycles -> out_valid, out_tag and out_data are stable; the pop occurs on the first out_ready=1 cycle.
REQ-045 Reset mid-flight: 6 outstanding with 3 received, assert rst for 1 cycle -> occupancy=0 and out_valid=0; a late response to tag 2 raises rsp_err.
